// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, register ids,
// the W-register bundle with its nop value, and M-stage FSM states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mstate_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic        cond;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        hlt;
    logic        in_inst;
    logic        in_mem;
  } w_reg_t;

  localparam w_reg_t W_NOP = '{
    icode:   I_NOP,
    cond:    1'b1,
    valE:    64'd0,
    valM:    64'd0,
    dstE:    RNONE,
    dstM:    RNONE,
    hlt:     1'b0,
    in_inst: 1'b0,
    in_mem:  1'b0
  };

endpackage

// File: rtl/dmem_access_ctrl.sv
// Data-memory handshake FSM (IDLE/ACCESS/DONE) with the valM holding register.
// Ports: need/we/addr/wdata request in; dmem_* bus; stall, done, held valM, tmo out.
// Macro DMEM_TIMEOUT_EN adds an ack-wait limit of TIMEOUT_CYCLES cycles.
module dmem_access_ctrl
  import y86_pkg::*;
`ifdef DMEM_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        need,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] held,
  output logic        tmo
);

  mstate_t state;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
    $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LIM =
    CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  logic          tmo_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
      held       <= 64'd0;
`ifdef DMEM_TIMEOUT_EN
      cnt        <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
`ifdef DMEM_TIMEOUT_EN
          cnt   <= '0;
          tmo_q <= 1'b0;
`endif
          if (need) begin
            dmem_req   <= 1'b1;
            dmem_we    <= we;
            dmem_addr  <= addr;
            dmem_wdata <= wdata;
            state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (dmem_ack) begin
            held     <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= S_DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (cnt == LIM) begin
            held     <= 64'd0;
            dmem_req <= 1'b0;
            tmo_q    <= 1'b1;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall = (state == S_ACCESS) ||
                 ((state == S_IDLE) && need);
  assign done  = (state == S_DONE);

`ifdef DMEM_TIMEOUT_EN
  assign tmo = tmo_q && done;
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: rtl/memory_stage.sv
// Y86-64 M stage: decode, address check, flag merge, W register.
// Ports: M_* in, W_* out, dmem_* req/ack bus, m_stall/m_valM/m_in_mem comb.
// Macro DMEM_TIMEOUT_EN enables the ack timeout (TIMEOUT_CYCLES).
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  M_icode,
  input  logic        M_cond,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        M_hlt,
  input  logic        M_in_inst,
  input  logic        M_in_mem,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        m_stall,
  output logic [63:0] m_valM,
  output logic        m_in_mem,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic        W_cond,
  output logic        W_hlt,
  output logic        W_in_inst,
  output logic        W_in_mem
);

  localparam logic [63:0] ADDR_MAX =
    64'(MEM_BYTES - 8);

  logic        rd;
  logic        wr;
  logic        use_a;
  logic [63:0] addr;
  logic        legal;
  logic        up_err;
  logic        need;
  logic        done;
  logic        tmo;
  logic [63:0] held;
  w_reg_t      w_q;

  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    use_a = 1'b0;
    unique case (M_icode)
      I_MRMOVQ: rd = 1'b1;
      I_POPQ, I_RET: begin
        rd    = 1'b1;
        use_a = 1'b1;
      end
      I_RMMOVQ, I_PUSHQ, I_CALL: wr = 1'b1;
      default: ;
    endcase
  end

  assign addr   = use_a ? M_valA : M_valE;
  assign legal  = (addr <= ADDR_MAX);
  assign up_err = M_hlt | M_in_inst | M_in_mem;
  assign need   = (rd | wr) & ~up_err & legal;

  dmem_access_ctrl
`ifdef DMEM_TIMEOUT_EN
  #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
  u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .need       (need),
    .we         (wr),
    .addr       (addr),
    .wdata      (M_valA),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .stall      (m_stall),
    .done       (done),
    .held       (held),
    .tmo        (tmo)
  );

  assign m_valM   = (done && rd) ? held : 64'd0;
  assign m_in_mem = M_in_mem |
                    ((rd | wr) & ~legal) |
                    tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= W_NOP;
    end else if (W_stall) begin
      w_q <= w_q;
    end else if (W_bubble || m_stall) begin
      w_q <= W_NOP;
    end else begin
      w_q <= '{
        icode:   M_icode,
        cond:    M_cond,
        valE:    M_valE,
        valM:    m_valM,
        dstE:    M_dstE,
        dstM:    M_dstM,
        hlt:     M_hlt,
        in_inst: M_in_inst,
        in_mem:  m_in_mem
      };
    end
  end

  assign W_icode   = w_q.icode;
  assign W_cond    = w_q.cond;
  assign W_valE    = w_q.valE;
  assign W_valM    = w_q.valM;
  assign W_dstE    = w_q.dstE;
  assign W_dstM    = w_q.dstM;
  assign W_hlt     = w_q.hlt;
  assign W_in_inst = w_q.in_inst;
  assign W_in_mem  = w_q.in_mem;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed vectors push expected
// W contents; a monitor pops and compares on every W load.
module tb_memory_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  M_icode;
  logic        M_cond;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        M_hlt;
  logic        M_in_inst;
  logic        M_in_mem;
  logic        W_stall;
  logic        W_bubble;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        m_stall;
  logic [63:0] m_valM;
  logic        m_in_mem;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic        W_cond;
  logic        W_hlt;
  logic        W_in_inst;
  logic        W_in_mem;

  int checks = 0;
  int failures = 0;
  w_reg_t exp_q[$];
  w_reg_t last_exp;

  always #5 clk = ~clk;

  memory_stage #(
    .MEM_BYTES(8192)
`ifdef DMEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .M_icode(M_icode), .M_cond(M_cond),
    .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_hlt(M_hlt), .M_in_inst(M_in_inst),
    .M_in_mem(M_in_mem),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .m_stall(m_stall), .m_valM(m_valM),
    .m_in_mem(m_in_mem),
    .W_icode(W_icode), .W_dstE(W_dstE),
    .W_dstM(W_dstM), .W_valE(W_valE),
    .W_valM(W_valM), .W_cond(W_cond),
    .W_hlt(W_hlt), .W_in_inst(W_in_inst),
    .W_in_mem(W_in_mem)
  );

  function automatic w_reg_t w_act();
    return '{icode: W_icode, cond: W_cond,
             valE: W_valE, valM: W_valM,
             dstE: W_dstE, dstM: W_dstM,
             hlt: W_hlt, in_inst: W_in_inst,
             in_mem: W_in_mem};
  endfunction

  task automatic chk(input string nm,
                     input logic [143:0] act,
                     input logic [143:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  // Monitor: W loads at a posedge when, just before it, nothing held
  // or bubbled the register.
  initial begin : monitor
    logic   ld;
    w_reg_t e;
    forever begin
      @(negedge clk);
      ld = rst_n && !W_stall && !W_bubble && !m_stall;
      @(posedge clk);
      #1;
      if (ld) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL w_unexpected actual=%h required=none",
                   w_act());
        end else begin
          e = exp_q.pop_front();
          if (w_act() !== e) begin
            failures++;
            $display("FAIL w_reg actual=%h required=%h",
                     w_act(), e);
          end
        end
      end
    end
  end

  // Presents one instruction in M, plays the memory (ack in the
  // ack_dly-th request cycle) and counts stall/request cycles.
  task automatic issue(
    input string       nm,
    input logic [3:0]  ic,
    input logic [63:0] ve,
    input logic [63:0] va,
    input logic [3:0]  de,
    input logic [3:0]  dm,
    input logic        h,
    input logic        ii,
    input int          ack_dly,
    input logic [63:0] rdat,
    input int          x_stall,
    input int          x_req,
    input logic        x_we,
    input logic [63:0] x_addr,
    input logic [63:0] x_valM,
    input logic        x_inmem);
    w_reg_t e;
    int     stalls;
    int     reqs;
    bit     ok;
    M_icode = ic; M_cond = 1'b1;
    M_valE = ve; M_valA = va;
    M_dstE = de; M_dstM = dm;
    M_hlt = h; M_in_inst = ii; M_in_mem = 1'b0;
    W_stall = 1'b0; W_bubble = 1'b0;
    e = '{icode: ic, cond: 1'b1, valE: ve,
          valM: x_valM, dstE: de, dstM: dm,
          hlt: h, in_inst: ii, in_mem: x_inmem};
    exp_q.push_back(e);
    last_exp = e;
    stalls = 0; reqs = 0; ok = 0;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (dmem_req) begin
        if (reqs == 0) begin
          chk({nm, "_we"}, 144'(dmem_we), 144'(x_we));
          chk({nm, "_addr"}, 144'(dmem_addr), 144'(x_addr));
          if (x_we)
            chk({nm, "_wdata"}, 144'(dmem_wdata), 144'(va));
        end
        if (reqs == ack_dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdat;
        end
        reqs++;
      end
      if (!m_stall) begin
        ok = 1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_stall_bound actual=stuck required=release", nm);
    end
    chk({nm, "_stalls"}, 144'(stalls), 144'(x_stall));
    chk({nm, "_reqs"}, 144'(reqs), 144'(x_req));
    chk({nm, "_m_in_mem"}, 144'(m_in_mem), 144'(x_inmem));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    M_icode = I_NOP; M_cond = 1'b1;
    M_valE = '0; M_valA = '0;
    M_dstE = RNONE; M_dstM = RNONE;
    M_hlt = 0; M_in_inst = 0; M_in_mem = 0;
    W_stall = 0; W_bubble = 1;
    dmem_ack = 0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 144'(dmem_req), 144'(0));
    chk("rst_we", 144'(dmem_we), 144'(0));
    chk("rst_addr", 144'(dmem_addr), 144'(0));
    chk("rst_wdata", 144'(dmem_wdata), 144'(0));
    chk("rst_w", w_act(), W_NOP);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //     name  icode     valE      valA     dE     dM   h  ii dly rdata
    //     stall req we addr valM inmem
    issue("rmmovq", I_RMMOVQ, 64'h100, 64'h55, RNONE, RNONE, 0, 0,
          2, 64'h0, 4, 3, 1, 64'h100, 64'h0, 0);
    issue("mrmovq", I_MRMOVQ, 64'h40, 64'h0, RNONE, 4'h3, 0, 0,
          0, 64'hDEAD, 2, 1, 0, 64'h40, 64'hDEAD, 0);
    issue("mr_bad", I_MRMOVQ, 64'd8188, 64'h0, RNONE, 4'h3, 0, 0,
          0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 1);
    issue("opq", I_OPQ, 64'h7, 64'h0, 4'h2, RNONE, 0, 0,
          0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0);
    issue("pop_hlt", I_POPQ, 64'h108, 64'h200, 4'h4, 4'h5, 1, 0,
          0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0);
    issue("popq", I_POPQ, 64'h108, 64'h200, 4'h4, 4'h5, 0, 0,
          1, 64'h1234, 3, 2, 0, 64'h200, 64'h1234, 0);
    issue("call", I_CALL, 64'h1F0, 64'h77, 4'h4, RNONE, 0, 0,
          0, 64'h0, 2, 1, 1, 64'h1F0, 64'h0, 0);
    issue("mr_edge", I_MRMOVQ, 64'd8184, 64'h0, RNONE, 4'h6, 0, 0,
          0, 64'hBEEF, 2, 1, 0, 64'd8184, 64'hBEEF, 0);
    issue("ret_bad", I_RET, 64'h2001, 64'd8185, 4'h4, RNONE, 0, 0,
          0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 1);
    issue("push_ii", I_PUSHQ, 64'h80, 64'h9, 4'h4, RNONE, 0, 1,
          0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0);

    // W_stall holds, W_bubble loads nop
    M_icode = I_IRMOVQ; M_valE = 64'h9; M_dstE = 4'h1;
    M_in_inst = 0;
    W_stall = 1;
    @(posedge clk);
    #1;
    chk("w_stall_hold", w_act(), last_exp);
    W_stall = 0; W_bubble = 1;
    @(posedge clk);
    #1;
    chk("w_bubble_nop", w_act(), W_NOP);

    // reset in ACCESS, then a late ack
    M_icode = I_MRMOVQ; M_valE = 64'h80; M_dstM = 4'h3;
    @(posedge clk);
    #2;
    chk("mid_req_high", 144'(dmem_req), 144'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_req_drop", 144'(dmem_req), 144'(0));
    chk("mid_w_nop", w_act(), W_NOP);
    M_icode = I_NOP;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 64'hBAD;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    #1;
    chk("late_ack_req", 144'(dmem_req), 144'(0));
    chk("late_ack_stall", 144'(m_stall), 144'(0));
    issue("post_rst", I_OPQ, 64'h11, 64'h0, 4'h2, RNONE, 0, 0,
          0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0);

`ifdef DMEM_TIMEOUT_EN
    issue("tmo", I_MRMOVQ, 64'h300, 64'h0, RNONE, 4'h3, 0, 0,
          1000, 64'h0, 5, 4, 0, 64'h300, 64'h0, 1);
    issue("post_tmo", I_MRMOVQ, 64'h48, 64'h0, RNONE, 4'h3, 0, 0,
          0, 64'h77, 2, 1, 0, 64'h48, 64'h77, 0);
`endif

    W_bubble = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 144'(exp_q.size()), 144'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
